// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   - uart_state_e : 3-bit frame state encoding (idle/start/data/parity/stop)
//   - OVERSAMPLE   : s_tick pulses per bit period
//   - DEF_NB_BIT, DEF_SB_TICK : default frame geometry
//   - even_parity  : parity bit that makes the total count of ones even
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int OVERSAMPLE  = 16;
  localparam int DEF_NB_BIT  = 8;
  localparam int DEF_SB_TICK = 16;

  // Callers zero-extend their data word, so the unused upper bits do not
  // disturb the reduction.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// uart_tx: UART serial transmitter.
// Serializes din LSB-first as start bit, NB_BIT data bits, optional even
// parity bit and a stop interval of SB_TICK s_tick periods. All bit timing
// comes from the shared 16x baud enable s_tick.
//
// Ports:
//   clk          in   clock
//   reset        in   synchronous, active-high reset
//   s_tick       in   baud enable, 16 pulses per bit, one clk wide
//   tx_start     in   request to send din, honoured only when idle
//   din          in   [NB_BIT-1:0] word captured on an accepted tx_start
//   tx           out  registered serial line, idles high
//   tx_busy      out  high whenever a frame is in progress
//   tx_done_tick out  one-cycle pulse with the final stop s_tick
//
// Build option: define UART_TX_PARITY_EN to emit an even-parity bit between
// the data bits and the stop interval; without it data goes straight to stop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int NB_BIT  = DEF_NB_BIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tick,
  input  logic              tx_start,
  input  logic [NB_BIT-1:0] din,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);

  localparam int TW = ($clog2(SB_TICK) < 4) ? 4 : $clog2(SB_TICK);
  localparam int BW = (NB_BIT > 1) ? $clog2(NB_BIT) : 1;

  uart_state_e       state_q, state_d;
  logic [TW-1:0]     s_q, s_d;
  logic [BW-1:0]     n_q, n_d;
  logic [NB_BIT-1:0] b_q, b_d;
  logic              tx_q, tx_d;
  logic              done_d;
`ifdef UART_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      tx_q    <= tx_d;
    end
    // Shift register and parity are only meaningful inside a frame, so they
    // are left out of reset.
    b_q <= b_d;
`ifdef UART_TX_PARITY_EN
    par_q <= par_d;
`endif
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          b_d     = din;
          s_d     = '0;
          state_d = ST_START;
`ifdef UART_TX_PARITY_EN
          // Parity is fixed at capture so later din changes cannot leak in.
          par_d   = even_parity(32'(din));
`endif
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == TW'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == TW'(OVERSAMPLE - 1)) begin
            s_d = '0;
            b_d = b_q >> 1;
            n_d = n_q + 1'b1;
            if (n_q == BW'(NB_BIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == TW'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == TW'(SB_TICK - 1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The line level is chosen from the next state so the registered tx
    // lines up with the state register, one clk after the decision.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign tx_busy      = (state_q != ST_IDLE);
  // Masked during reset so an abandoned frame never reports completion.
  assign tx_done_tick = done_d & ~reset;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx.
// Two instances share clk, reset and s_tick: u_dut0 with one stop bit
// (SB_TICK=16) and u_dut1 with two stop bits (SB_TICK=32). Stimulus pushes
// the hand-computed expected frame into a per-instance queue; a monitor
// decodes the serial line at mid-bit and checks each frame when the DUT
// raises tx_done_tick. Honours UART_TX_PARITY_EN like the design.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int PAR_ON = 1;
`else
  localparam int PAR_ON = 0;
`endif
  localparam int FRAME16  = PAR_ON ? 176 : 160;
  localparam int FRAME32  = PAR_ON ? 192 : 176;
  localparam int STOP_IDX = 9 + PAR_ON;
  localparam int TMO      = 900;

  typedef struct packed {
    logic [7:0]  data;
    logic        slot9;   // parity bit, or stop level when parity is absent
    logic [31:0] ticks;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, s_tick, start0, start1;
  logic [7:0] din0, din1;
  logic       tx0, busy0, done0, tx1, busy1, done1;
  int         tdiv;

  int n_cmp = 0;
  int n_mis = 0;

  exp_t        q0[$];
  exp_t        q1[$];
  logic        act_m[2]    = '{1'b0, 1'b0};
  int          cnt_m[2]    = '{0, 0};
  logic [15:0] samp_m[2]   = '{16'hFFFF, 16'hFFFF};
  int          done_cnt[2] = '{0, 0};

  uart_tx #(.NB_BIT(8), .SB_TICK(16)) u_dut0 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start0), .din(din0),
    .tx(tx0), .tx_busy(busy0), .tx_done_tick(done0)
  );

  uart_tx #(.NB_BIT(8), .SB_TICK(32)) u_dut1 (
    .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(start1), .din(din1),
    .tx(tx1), .tx_busy(busy1), .tx_done_tick(done1)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Baud enable: one pulse every third clk.
  initial begin
    s_tick = 1'b0;
    tdiv   = 0;
    forever begin
      cyc();
      tdiv   = (tdiv + 1) % 3;
      s_tick = (tdiv == 0);
    end
  end

  task automatic mon_step(input int k);
    logic txv, dn;
    exp_t e;
    int   idx;
    txv = (k == 0) ? tx0 : tx1;
    dn  = (k == 0) ? done0 : done1;
    if (reset) begin
      act_m[k] = 1'b0;
      return;
    end
    if (!act_m[k] && txv == 1'b0) begin
      act_m[k]  = 1'b1;
      cnt_m[k]  = 0;
      samp_m[k] = 16'hFFFF;
    end
    if (act_m[k] && s_tick) begin
      cnt_m[k]++;
      idx = (cnt_m[k] - 1) / 16;
      if ((cnt_m[k] - 1) % 16 == 7 && idx < 16) samp_m[k][idx] = txv;
    end
    if (dn) begin
      done_cnt[k]++;
      if (!act_m[k] || ((k == 0) ? q0.size() : q1.size()) == 0) begin
        n_cmp++;
        n_mis++;
        $display("FAIL sb%0d_unexpected_done: got a done pulse, expected no frame pending", k);
      end else begin
        if (k == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("sb%0d_start_bit", k), int'(samp_m[k][0]), 0);
        chk($sformatf("sb%0d_data", k), int'(samp_m[k][8:1]), int'(e.data));
        chk($sformatf("sb%0d_slot9", k), int'(samp_m[k][9]), int'(e.slot9));
        chk($sformatf("sb%0d_stop_bit", k), int'(samp_m[k][STOP_IDX]), 1);
        chk($sformatf("sb%0d_frame_ticks", k), cnt_m[k], int'(e.ticks));
      end
      act_m[k] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    mon_step(0);
    mon_step(1);
  end

  task automatic push(input int k, input logic [7:0] d, input logic p, input int t);
    exp_t e;
    e.data  = d;
    e.slot9 = (PAR_ON != 0) ? p : 1'b1;
    e.ticks = t;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic send0(input logic [7:0] d, input string nm);
    cyc();
    din0   = d;
    start0 = 1'b1;
    cyc();
    start0 = 1'b0;
    @(negedge clk);
    chk({nm, "_busy"}, int'(busy0), 1);
    chk({nm, "_tx_start"}, int'(tx0), 0);
  endtask

  task automatic wait_done(input int k, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (((k == 0) ? done0 : done1) == 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_mis++;
      $display("FAIL %s_timeout: no done pulse within %0d cycles, expected one", nm, TMO);
    end
  endtask

  task automatic wait_ticks(input int n);
    int c = 0;
    while (c < n) begin
      @(negedge clk);
      if (s_tick) c++;
    end
  endtask

  initial begin
    int dc;
    reset  = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    din0   = 8'h00;
    din1   = 8'h00;
    repeat (3) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_tx0", int'(tx0), 1);
    chk("rst_busy0", int'(busy0), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_tx1", int'(tx1), 1);
    chk("rst_busy1", int'(busy1), 0);

    // 0xA5: bits 1,0,1,0,0,1,0,1, four ones -> parity 0
    push(0, 8'hA5, 1'b0, FRAME16);
    send0(8'hA5, "a5");
    wait_done(0, "a5");

    // 0x07: three ones -> parity 1
    push(0, 8'h07, 1'b1, FRAME16);
    send0(8'h07, "x07");
    wait_done(0, "x07");

    // Busy frame: din and tx_start change mid-frame and must be ignored
    push(0, 8'hC3, 1'b0, FRAME16);
    send0(8'hC3, "c3");
    wait_ticks(38);
    cyc();
    din0   = 8'h3C;
    start0 = 1'b1;
    cyc();
    start0 = 1'b0;
    wait_done(0, "c3");
    repeat (20) @(negedge clk);
    chk("no_queue_busy", int'(busy0), 0);

    // Reset during data bit 3 abandons the frame
    dc = done_cnt[0];
    send0(8'hF0, "abort");
    wait_ticks(70);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_tx", int'(tx0), 1);
    chk("abort_busy", int'(busy0), 0);
    chk("abort_done", int'(done0), 0);
    repeat (400) @(negedge clk);
    chk("abort_no_done", done_cnt[0], dc);

    // 0x55 after the reset: four ones -> parity 0
    push(0, 8'h55, 1'b0, FRAME16);
    send0(8'h55, "x55");
    wait_done(0, "x55");

    // Two stop bits, tx_start held through the done cycle
    cyc();
    din1   = 8'hFF;
    start1 = 1'b1;
    push(1, 8'hFF, 1'b0, FRAME32);
    cyc();
    din1 = 8'h81;
    push(1, 8'h81, 1'b0, FRAME32);
    @(negedge clk);
    chk("ff_busy", int'(busy1), 1);
    wait_done(1, "ff");
    chk("b2b_busy_at_done", int'(busy1), 1);
    @(negedge clk);
    chk("b2b_gap_busy", int'(busy1), 0);
    chk("b2b_gap_tx", int'(tx1), 1);
    cyc();
    start1 = 1'b0;
    @(negedge clk);
    chk("b2b_next_busy", int'(busy1), 1);
    chk("b2b_next_tx", int'(tx1), 0);
    wait_done(1, "x81");

    // 0x80: one one -> parity 1; without parity the frame is 160 ticks
    push(0, 8'h80, 1'b1, FRAME16);
    send0(8'h80, "x80");
    wait_done(0, "x80");

    repeat (5) cyc();
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("done_count0", done_cnt[0], 5);
    chk("done_count1", done_cnt[1], 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
